inverter_bank: RTL and testbench

INVERTER_BANK -- requirements
Module: inverter_bank

---
 rtl/inverter_bank.sv | 172 +++++++++++++++++
 tb/tb_inverter_bank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/inverter_bank.sv
// inverter_bank: a bank of CHANNELS independent XOR gates. Each channel passes i_x when
// i_mode is 0 and inverts it when i_mode is 1. A DELAY-deep register pipeline emulates
// propagation delay, and i_oe gates the output.
// Optional built-in self-test: define INVERTER_BANK_BIST_EN to include it. The self-test
// walks a one-hot pattern through every channel and checks what comes out of the pipeline.
// With the macro undefined, the BIST outputs are tied to 0 and i_bist_start is ignored.

module inverter_bank #(
    parameter int unsigned CHANNELS = 6,
    parameter int unsigned DELAY    = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [CHANNELS-1:0] i_x,
    input  logic [CHANNELS-1:0] i_mode,
    input  logic                i_oe,
    input  logic                i_bist_start,
    output logic [CHANNELS-1:0] o_y,
    output logic                o_bist_busy,
    output logic                o_bist_done,
    output logic                o_bist_pass
);

    logic [CHANNELS-1:0] pipe_q [DELAY];
    logic [CHANNELS-1:0] stage0_d;
    logic                bist_load;
    logic                bist_busy;
    logic [CHANNELS-1:0] bist_pat;

    // Stage 0 takes the test pattern while the self-test owns the pipeline, else live data.
    always_comb begin
        stage0_d = (bist_load ? bist_pat : i_x) ^ i_mode;
    end

    // Delay pipeline: it keeps shifting even while the output is disabled.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < DELAY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= stage0_d;
            for (int unsigned i = 1; i < DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Output gate: the output is forced low when disabled or while a self-test is running.
    always_comb begin
        o_y = (i_oe && !bist_busy) ? pipe_q[DELAY-1] : '0;
    end

`ifdef INVERTER_BANK_BIST_EN

    localparam int unsigned PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [PW-1:0]       P_LAST    = PW'(CHANNELS - 1);
    localparam logic [2:0]          WAIT_LAST = 3'((DELAY > 1) ? DELAY - 2 : 0);
    localparam logic [CHANNELS-1:0] ONE       = CHANNELS'(1);

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StWait,
        StCheck,
        StDone
    } bist_state_e;

    bist_state_e   state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          fail_q, fail_d;
    logic          pass_q, pass_d;

    // Walking-one pattern for the channel currently under test.
    always_comb begin
        bist_pat = ONE << p_q;
    end

    // BIST state and bookkeeping registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            p_q     <= '0;
            cnt_q   <= '0;
            fail_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    // BIST next-state logic.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle: begin
                if (i_bist_start) begin
                    fail_d  = 1'b0;
                    p_d     = '0;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                cnt_d   = '0;
                state_d = (DELAY > 1) ? StWait : StCheck;
            end
            StWait: begin
                // DELAY-1 cycles spent waiting for the pattern to reach the last stage.
                if (cnt_q == WAIT_LAST) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCheck: begin
                // The expected value uses the i_mode of this cycle, not the cycle it was driven.
                if (pipe_q[DELAY-1] != (bist_pat ^ i_mode)) begin
                    fail_d = 1'b1;
                end
                if (p_q == P_LAST) begin
                    state_d = StDone;
                end else begin
                    p_d     = p_q + 1'b1;
                    state_d = StDrive;
                end
            end
            StDone: begin
                pass_d  = ~fail_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // BIST status outputs. The result is already visible during the done pulse.
    always_comb begin
        bist_busy   = (state_q == StDrive) || (state_q == StWait) || (state_q == StCheck);
        bist_load   = bist_busy;
        o_bist_busy = bist_busy;
        o_bist_done = (state_q == StDone);
        o_bist_pass = (state_q == StDone) ? ~fail_q : pass_q;
    end

`else

    logic unused_bist_start;

    // No self-test: live data always feeds the pipeline and the status outputs stay low.
    always_comb begin
        unused_bist_start = i_bist_start;
        bist_pat          = '0;
        bist_load         = 1'b0;
        bist_busy         = 1'b0;
        o_bist_busy       = 1'b0;
        o_bist_done       = 1'b0;
        o_bist_pass       = 1'b0;
    end

`endif

endmodule

// File: tb/tb_inverter_bank.sv
// tb_inverter_bank: directed self-checking bench for inverter_bank.
// Main instance: CHANNELS=6, DELAY=2. Small instance: CHANNELS=1, DELAY=1.
// The BIST checks run when INVERTER_BANK_BIST_EN is defined. Otherwise the bench checks
// that i_bist_start leaves every BIST output at 0.

module tb_inverter_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] x, mode, y;
    logic       oe, start, busy, done, pass;
    logic [0:0] x1, mode1, y1;
    logic       oe1, start1, busy1, done1, pass1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inverter_bank #(.CHANNELS(6), .DELAY(2)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_x          (x),
        .i_mode       (mode),
        .i_oe         (oe),
        .i_bist_start (start),
        .o_y          (y),
        .o_bist_busy  (busy),
        .o_bist_done  (done),
        .o_bist_pass  (pass)
    );

    inverter_bank #(.CHANNELS(1), .DELAY(1)) dut_s (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_x          (x1),
        .i_mode       (mode1),
        .i_oe         (oe1),
        .i_bist_start (start1),
        .o_y          (y1),
        .o_bist_busy  (busy1),
        .o_bist_done  (done1),
        .o_bist_pass  (pass1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance n clock edges, then settle 1ns past the last edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

`ifdef INVERTER_BANK_BIST_EN
    // Run one BIST on the main instance and count busy cycles. Index arguments of -1 are
    // disabled. glitch_n flips i_mode[2] in that busy cycle. abort_n asserts reset in that
    // busy cycle. restart_n pulses start again in that busy cycle.
    task automatic run_bist(input int glitch_n, input int abort_n, input int restart_n,
                            output int busy_n, output int ybad);
        busy_n = 0;
        ybad   = 0;
        start  = 1'b1;
        step(1);
        start  = 1'b0;
        while (busy && busy_n < 40) begin
            if (y !== 6'h00) ybad++;
            mode  = (busy_n == glitch_n) ? 6'h3B : 6'h3F;
            start = (busy_n == restart_n);
            rst   = (busy_n == abort_n);
            busy_n++;
            step(1);
            if (rst) begin
                rst = 1'b0;
                break;
            end
        end
        mode  = 6'h3F;
        start = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        int n;
        int yb;
        int seen;

        rst = 1'b1; x = 6'h00; mode = 6'h3F; oe = 1'b1; start = 1'b0;
        x1 = 1'b1; mode1 = 1'b0; oe1 = 1'b1; start1 = 1'b0;
        step(2);
        check("rst_y", y, 6'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_y1", y1, 0);
        rst = 1'b0;

        // Pipeline fill after reset, then the latency step 00 -> 15 with all channels inverted.
        step(2);
        check("fill_y", y, 6'h3F);
        check("small_buf", y1, 1);
        x = 6'h15;
        step(1);
        check("lat_hold", y, 6'h3F);
        step(1);
        check("lat_new", y, 6'h2A);
        mode1 = 1'b1;
        step(1);
        check("small_inv", y1, 0);

        // Mixed polarity and the output enable, which acts in the same cycle.
        mode = 6'h0F; x = 6'h33;
        step(2);
        check("mix_y", y, 6'h3C);
        oe = 1'b0;
        #1;
        check("oe_off", y, 6'h00);
        oe = 1'b1;
        #1;
        check("oe_on", y, 6'h3C);

        // Changing channel 2 alone moves only output bit 2.
        x = 6'h37;
        step(2);
        check("indep_y", y, 6'h38);

        // New data shifts through while the output is disabled.
        oe = 1'b0; mode = 6'h00; x = 6'h2A;
        step(2);
        check("oe_low_y", y, 6'h00);
        oe = 1'b1;
        #1;
        check("oe_shift", y, 6'h2A);

`ifdef INVERTER_BANK_BIST_EN
        x = 6'h00; mode = 6'h3F; x1 = 1'b0; mode1 = 1'b0;
        step(2);

        run_bist(-1, -1, -1, n, yb);
        check("clean_busy_n", n, 18);
        check("clean_y_zero", yb, 0);
        check("clean_done", done, 1);
        check("clean_pass", pass, 1);
        step(1);
        check("clean_done_off", done, 0);
        check("clean_pass_hold", pass, 1);
        check("clean_busy_off", busy, 0);
        step(1);
        check("refill_y", y, 6'h3F);

        run_bist(8, -1, -1, n, yb);
        check("glitch_busy_n", n, 18);
        check("glitch_done", done, 1);
        check("glitch_pass", pass, 0);
        step(2);

        run_bist(-1, -1, 5, n, yb);
        check("restart_busy_n", n, 18);
        check("restart_done", done, 1);
        check("restart_pass", pass, 1);
        step(2);

        run_bist(-1, 7, -1, n, yb);
        check("abort_busy", busy, 0);
        check("abort_pass", pass, 0);
        check("abort_done", done, 0);
        check("abort_y", y, 6'h00);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);

        run_bist(-1, -1, -1, n, yb);
        check("after_abort_n", n, 18);
        check("after_abort_pass", pass, 1);

        start1 = 1'b1;
        step(1);
        start1 = 1'b0;
        n = 0;
        while (busy1 && n < 10) begin
            n++;
            step(1);
        end
        check("small_busy_n", n, 2);
        check("small_done", done1, 1);
        check("small_pass", pass1, 1);
`else
        start = 1'b1; start1 = 1'b1;
        step(1);
        start = 1'b0; start1 = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy || done || pass || busy1 || done1 || pass1) seen++;
            step(1);
        end
        check("nobist_outs", seen, 0);
        check("nobist_y", y, 6'h2A);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
